// File: rtl/axi_arbiter_w_n.sv
// ---------------------------------------------------------------------------
// axi_arbiter_w_n
//
// N-master AXI4 write-channel arbiter. One master at a time owns the shared
// slave write path. Its grant is held from the AW request through the W
// burst (up to WLAST) and until the B handshake completes. The grant is
// given as a one-hot vector for the per-master ready/valid gating and as a
// binary index that steers the interconnect write muxes.
//
// Handshake semantics: a transfer happens on a rising ACLK edge where both
// valid and ready of a channel are high. The per-master valids, WLAST and
// BREADY are qualified here with the current grant index g. AWREADY,
// WREADY and BVALID come from the already-muxed slave side.
//
// Parameters
//   N_MST        number of masters (2..16)
//   ARB_MODE     0 = round-robin, 1 = fixed priority (lowest index wins)
//   TIMEOUT_CYC  watchdog limit in cycles (used only with the watchdog)
//   IDX_W        grant index width, derived from N_MST
//
// Ports
//   ACLK, ARESET        clock; synchronous active-high reset
//   m_AWVALID[N_MST]    per-master write-address valid (grant requests)
//   m_WVALID[N_MST]     per-master write-data valid
//   m_WLAST[N_MST]      per-master last write beat
//   m_BREADY[N_MST]     per-master write-response ready
//   AWREADY/WREADY      slave-side address / data ready
//   BVALID              slave-side write-response valid
//   m_wgrnt[N_MST]      registered one-hot grant (all zero when idle)
//   wgrnt_idx[IDX_W]    binary grant index, meaningful while wgrnt_vld = 1
//   wgrnt_vld           a grant is active
//   arb_timeout         one-cycle watchdog abort pulse
//
// Build option
//   AXI_ARB_W_TIMEOUT_EN  when defined, a watchdog aborts a stalled grant
//                         after TIMEOUT_CYC cycles without a handshake of
//                         the granted master. When undefined, arb_timeout
//                         is tied low. The port list is the same either way.
//
// The FSM state is kept in the signal 'state' (state_t). Its encoding is
// fixed (IDLE=0, ADDR=1, DATA=2, RESP=3) so that checkers can bind to it.
// ---------------------------------------------------------------------------
module axi_arbiter_w_n #(
  parameter int N_MST       = 4,
  parameter int ARB_MODE    = 0,
  parameter int TIMEOUT_CYC = 1024,
  parameter int IDX_W       = $clog2(N_MST)
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic [N_MST-1:0] m_AWVALID,
  input  logic [N_MST-1:0] m_WVALID,
  input  logic [N_MST-1:0] m_WLAST,
  input  logic [N_MST-1:0] m_BREADY,
  input  logic             AWREADY,
  input  logic             WREADY,
  input  logic             BVALID,
  output logic [N_MST-1:0] m_wgrnt,
  output logic [IDX_W-1:0] wgrnt_idx,
  output logic             wgrnt_vld,
  output logic             arb_timeout
);

  // Reject unsupported configurations at elaboration time.
  if (N_MST < 2 || N_MST > 16 || ARB_MODE < 0 || ARB_MODE > 1 ||
      TIMEOUT_CYC < 1) begin : g_param_check
    $error("axi_arbiter_w_n: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;

  // Index of the most recent grant. The round-robin search starts one above it.
  logic [IDX_W-1:0] ptr;

  logic [IDX_W-1:0] rr_win;
  logic             rr_found;
  logic [IDX_W-1:0] rr_cand;
  logic [IDX_W-1:0] fp_win;
  logic [IDX_W-1:0] win;
  logic [N_MST-1:0] win_oh;

  logic             any_req;
  logic             aw_hs;
  logic             w_last_hs;
  logic             b_hs;
  logic             load;       // capture a new winner on this edge
  logic             release_g;  // drop the grant on this edge
  logic             abort;      // watchdog expiry

  assign any_req   = |m_AWVALID;
  assign aw_hs     = m_AWVALID[wgrnt_idx] & AWREADY;
  assign w_last_hs = m_WVALID[wgrnt_idx] & WREADY & m_WLAST[wgrnt_idx];
  assign b_hs      = BVALID & m_BREADY[wgrnt_idx];

  // Round-robin: the first requester strictly after ptr, wrapping modulo
  // N_MST. ptr itself is examined last, so a sole requester still wins.
  always_comb begin
    rr_win   = ptr;
    rr_found = 1'b0;
    rr_cand  = '0;
    for (int k = 1; k <= N_MST; k++) begin
      rr_cand = IDX_W'((int'(ptr) + k) % N_MST);
      if (!rr_found && m_AWVALID[rr_cand]) begin
        rr_win   = rr_cand;
        rr_found = 1'b1;
      end
    end
  end

  // Fixed priority: the lowest set index wins. The scan runs downward so
  // that the last write is the lowest requester.
  always_comb begin
    fp_win = '0;
    for (int k = N_MST - 1; k >= 0; k--) begin
      if (m_AWVALID[IDX_W'(k)]) begin
        fp_win = IDX_W'(k);
      end
    end
  end

  assign win    = (ARB_MODE == 1) ? fp_win : rr_win;
  assign win_oh = N_MST'(1) << win;

  // Next-state logic. Only the B handshake, the watchdog and reset move the
  // FSM out of a granted state without following the address/data order.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    release_g = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = ADDR;
          load      = 1'b1;
        end
      end
      ADDR: begin
        // A single-beat write may finish its W beat in the same cycle as
        // its AW handshake. In that case the DATA state is skipped.
        if (aw_hs) begin
          if (w_last_hs) begin
            state_nxt = RESP;
          end else begin
            state_nxt = DATA;
          end
        end
      end
      DATA: begin
        if (w_last_hs) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        // Go straight to the next winner if anyone is waiting.
        // This avoids an idle bubble between back-to-back writes.
        if (b_hs) begin
          if (any_req) begin
            state_nxt = ADDR;
            load      = 1'b1;
          end else begin
            state_nxt = IDLE;
            release_g = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        release_g = 1'b1;
      end
    endcase
    if (abort) begin
      state_nxt = IDLE;
      load      = 1'b0;
      release_g = 1'b1;
    end
  end

  // State, grant and pointer registers. On a watchdog abort ptr is left
  // unchanged. It still holds g, so g has the lowest round-robin priority
  // afterwards. wgrnt_idx keeps its last value while no grant is active.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state     <= IDLE;
      m_wgrnt   <= '0;
      wgrnt_idx <= '0;
      wgrnt_vld <= 1'b0;
      ptr       <= IDX_W'(N_MST - 1);
    end else begin
      state <= state_nxt;
      if (load) begin
        m_wgrnt   <= win_oh;
        wgrnt_idx <= win;
        wgrnt_vld <= 1'b1;
        ptr       <= win;
      end else if (release_g) begin
        m_wgrnt   <= '0;
        wgrnt_vld <= 1'b0;
      end
    end
  end

`ifdef AXI_ARB_W_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] to_cnt;
  logic             hs_g;

  // Any handshake of the granted master shows that it is still making progress.
  assign hs_g = ((state == ADDR) && aw_hs) ||
                ((state == DATA) && m_WVALID[wgrnt_idx] && WREADY) ||
                ((state == RESP) && b_hs);

  // The counter restarts on every new grant (load), on every handshake of g,
  // and whenever the FSM is idle or about to become idle.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      to_cnt <= '0;
    end else if (load || hs_g || (state_nxt == IDLE)) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + CNT_W'(1);
    end
  end

  // This decode comes only from registers. It is high for exactly one cycle,
  // because abort sends the FSM to IDLE on the next edge.
  assign abort       = (state != IDLE) && (to_cnt == CNT_W'(TIMEOUT_CYC));
  assign arb_timeout = abort;
`else
  assign abort       = 1'b0;
  assign arb_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_axi_arbiter_w_n.sv
// ---------------------------------------------------------------------------
// tb_axi_arbiter_w_n
//
// Bench for axi_arbiter_w_n with 4 masters. dut0 runs round-robin and dut1
// runs fixed priority. Both instances share the same stimulus. Inputs change
// just after a falling edge and outputs are sampled on the falling edge, so
// every tick covers exactly one rising edge. Expected grant indices are
// queued when a scenario drives its requests and are popped when a grant
// event appears. Watchdog expectations follow AXI_ARB_W_TIMEOUT_EN, and the
// instances are built with TIMEOUT_CYC = 32.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axi_arbiter_w_n;

  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic         aclk = 1'b0;
  logic         areset;
  always #5 aclk = ~aclk;

  logic [N-1:0] m_awvalid, m_wvalid, m_wlast, m_bready;
  logic         awready, wready, bvalid;

  logic [N-1:0] grnt0, grnt1;
  logic [1:0]   idx0, idx1;
  logic         vld0, vld1, to0, to1;
  logic [1:0]   st0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  int checks   = 0;
  int failures = 0;

  logic [1:0] exp_q[$];
  logic [1:0] exp1_q[$];
  logic [1:0] e, e1;
  logic [3:0] e_oh;

  axi_arbiter_w_n #(.N_MST(N), .ARB_MODE(0), .TIMEOUT_CYC(32)) dut0 (
    .ACLK(aclk), .ARESET(areset),
    .m_AWVALID(m_awvalid), .m_WVALID(m_wvalid), .m_WLAST(m_wlast), .m_BREADY(m_bready),
    .AWREADY(awready), .WREADY(wready), .BVALID(bvalid),
    .m_wgrnt(grnt0), .wgrnt_idx(idx0), .wgrnt_vld(vld0), .arb_timeout(to0)
  );

  axi_arbiter_w_n #(.N_MST(N), .ARB_MODE(1), .TIMEOUT_CYC(32)) dut1 (
    .ACLK(aclk), .ARESET(areset),
    .m_AWVALID(m_awvalid), .m_WVALID(m_wvalid), .m_WLAST(m_wlast), .m_BREADY(m_bready),
    .AWREADY(awready), .WREADY(wready), .BVALID(bvalid),
    .m_wgrnt(grnt1), .wgrnt_idx(idx1), .wgrnt_vld(vld1), .arb_timeout(to1)
  );

  assign st0 = dut0.state;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge aclk);
  endtask

  task automatic drive_idle();
    m_awvalid = '0; m_wvalid = '0; m_wlast = '0; m_bready = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
  endtask

  task automatic pulse_reset();
    areset = 1'b1;
    drive_idle();
    tick();
    areset = 1'b0;
  endtask

  // Slave always ready and every master always valid and last: each grant
  // takes one ADDR cycle (AW and WLAST together) and one RESP cycle.
  task automatic drive_stream(input logic [N-1:0] req);
    m_awvalid = req; m_wvalid = '1; m_wlast = '1; m_bready = '1;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    areset = 1'b1;
    drive_idle();
    tick(); tick();
    checks++; if (grnt0 !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b exp=%b", grnt0, 4'b0000); end
    checks++; if (vld0 !== 1'b0) begin failures++; $display("FAIL reset_vld got=%b exp=0", vld0); end
    checks++; if (idx0 !== 2'd0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", idx0); end
    checks++; if (to0 !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", to0); end
    checks++; if (st0 !== S_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", st0, S_IDLE); end
    checks++; if (grnt1 !== 4'b0000) begin failures++; $display("FAIL reset_grant_fp got=%b exp=%b", grnt1, 4'b0000); end
    areset = 1'b0;
  endtask

  task automatic test_single_burst();
    exp_q.push_back(2'd2);
    m_awvalid = 4'b0100; awready = 1'b1;
    tick();
    e = exp_q.pop_front();
    checks++; if (grnt0 !== 4'b0100) begin failures++; $display("FAIL burst_grant got=%b exp=%b", grnt0, 4'b0100); end
    checks++; if (idx0 !== e) begin failures++; $display("FAIL burst_idx got=%0d exp=%0d", idx0, e); end
    checks++; if (vld0 !== 1'b1) begin failures++; $display("FAIL burst_vld got=%b exp=1", vld0); end
    tick();
    checks++; if (st0 !== S_DATA) begin failures++; $display("FAIL burst_aw_state got=%0d exp=%0d", st0, S_DATA); end
    m_awvalid = '0; awready = 1'b0; m_wvalid = 4'b0100; wready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      m_wlast = (i == 15) ? 4'b0100 : 4'b0000;
      tick();
      checks++; if (grnt0 !== 4'b0100) begin failures++; $display("FAIL burst_hold beat=%0d got=%b exp=%b", i, grnt0, 4'b0100); end
    end
    checks++; if (st0 !== S_RESP) begin failures++; $display("FAIL burst_resp_state got=%0d exp=%0d", st0, S_RESP); end
    m_wvalid = '0; m_wlast = '0; wready = 1'b0; bvalid = 1'b1; m_bready = 4'b0100;
    tick();
    checks++; if (grnt0 !== 4'b0000) begin failures++; $display("FAIL burst_release got=%b exp=%b", grnt0, 4'b0000); end
    checks++; if (vld0 !== 1'b0) begin failures++; $display("FAIL burst_release_vld got=%b exp=0", vld0); end
    checks++; if (idx0 !== 2'd2) begin failures++; $display("FAIL burst_idx_hold got=%0d exp=2", idx0); end
    checks++; if (st0 !== S_IDLE) begin failures++; $display("FAIL burst_idle got=%0d exp=%0d", st0, S_IDLE); end
    drive_idle();
  endtask

  task automatic test_rr_order();
    pulse_reset();
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
    exp_q.push_back(2'd3); exp_q.push_back(2'd0);
    drive_stream(4'b1111);
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++; if (vld0 !== 1'b1) begin failures++; $display("FAIL rr_no_bubble cyc=%0d got=%b exp=1", c, vld0); end
      if (c % 2 == 0) begin
        e = exp_q.pop_front();
        e_oh = 4'b0001 << e;
        checks++; if (idx0 !== e) begin failures++; $display("FAIL rr_order cyc=%0d got=%0d exp=%0d", c, idx0, e); end
        checks++; if (grnt0 !== e_oh) begin failures++; $display("FAIL rr_onehot cyc=%0d got=%b exp=%b", c, grnt0, e_oh); end
        checks++; if (grnt1 !== 4'b0001) begin failures++; $display("FAIL fp_all_req cyc=%0d got=%b exp=%b", c, grnt1, 4'b0001); end
      end else begin
        checks++; if (st0 !== S_RESP) begin failures++; $display("FAIL rr_resp cyc=%0d got=%0d exp=%0d", c, st0, S_RESP); end
      end
    end
    drive_idle();
  endtask

  task automatic test_fixed_priority();
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back((i % 2 == 0) ? 2'd1 : 2'd3);
      exp1_q.push_back(2'd1);
    end
    drive_stream(4'b1010);
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++; if (vld1 !== 1'b1) begin failures++; $display("FAIL fp_vld cyc=%0d got=%b exp=1", c, vld1); end
      if (c % 2 == 0) begin
        e  = exp_q.pop_front();
        e1 = exp1_q.pop_front();
        checks++; if (idx1 !== e1) begin failures++; $display("FAIL fp_winner cyc=%0d got=%0d exp=%0d", c, idx1, e1); end
        checks++; if (grnt1 !== 4'b0010) begin failures++; $display("FAIL fp_grant cyc=%0d got=%b exp=%b", c, grnt1, 4'b0010); end
        checks++; if (idx0 !== e) begin failures++; $display("FAIL rr_alt cyc=%0d got=%0d exp=%0d", c, idx0, e); end
      end
    end
    drive_idle();
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    for (int i = 0; i < 4; i++) exp_q.push_back(2'd2);
    drive_stream(4'b0100);
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++; if (vld0 !== 1'b1) begin failures++; $display("FAIL b2b_vld cyc=%0d got=%b exp=1", c, vld0); end
      if (c % 2 == 0) begin
        e = exp_q.pop_front();
        checks++; if (idx0 !== e) begin failures++; $display("FAIL b2b_sole cyc=%0d got=%0d exp=%0d", c, idx0, e); end
        checks++; if (st0 !== S_ADDR) begin failures++; $display("FAIL b2b_addr cyc=%0d got=%0d exp=%0d", c, st0, S_ADDR); end
      end
    end
    drive_idle();
  endtask

  task automatic test_same_cycle();
    pulse_reset();
    exp_q.push_back(2'd1);
    m_awvalid = 4'b0010;
    tick();
    e = exp_q.pop_front();
    checks++; if (idx0 !== e) begin failures++; $display("FAIL sc_grant got=%0d exp=%0d", idx0, e); end
    // W last beat without AW acceptance must not advance the FSM.
    m_wvalid = 4'b0010; m_wlast = 4'b0010; wready = 1'b1;
    tick();
    checks++; if (st0 !== S_ADDR) begin failures++; $display("FAIL sc_w_before_aw got=%0d exp=%0d", st0, S_ADDR); end
    awready = 1'b1;
    tick();
    checks++; if (st0 !== S_RESP) begin failures++; $display("FAIL sc_addr_to_resp got=%0d exp=%0d", st0, S_RESP); end
    checks++; if (grnt0 !== 4'b0010) begin failures++; $display("FAIL sc_hold got=%b exp=%b", grnt0, 4'b0010); end
    drive_idle();
    bvalid = 1'b1; m_bready = 4'b0010;
    tick();
    checks++; if (grnt0 !== 4'b0000) begin failures++; $display("FAIL sc_release got=%b exp=%b", grnt0, 4'b0000); end
    checks++; if (st0 !== S_IDLE) begin failures++; $display("FAIL sc_idle got=%0d exp=%0d", st0, S_IDLE); end
    drive_idle();
  endtask

  task automatic test_reset_mid_data();
    pulse_reset();
    exp_q.push_back(2'd1);
    m_awvalid = 4'b0010;
    tick();
    e = exp_q.pop_front();
    checks++; if (idx0 !== e) begin failures++; $display("FAIL mid_first got=%0d exp=%0d", idx0, e); end
    awready = 1'b1;
    tick();
    // Masters 0 and 3 request while master 1 is bursting; the grant must not move.
    m_awvalid = 4'b1001; awready = 1'b0; m_wvalid = 4'b0010; wready = 1'b1;
    for (int b = 0; b < 5; b++) begin
      tick();
      checks++; if (grnt0 !== 4'b0010) begin failures++; $display("FAIL mid_hold beat=%0d got=%b exp=%b", b, grnt0, 4'b0010); end
    end
    areset = 1'b1;
    tick();
    checks++; if (grnt0 !== 4'b0000) begin failures++; $display("FAIL mid_reset_grant got=%b exp=%b", grnt0, 4'b0000); end
    checks++; if (vld0 !== 1'b0) begin failures++; $display("FAIL mid_reset_vld got=%b exp=0", vld0); end
    checks++; if (st0 !== S_IDLE) begin failures++; $display("FAIL mid_reset_state got=%0d exp=%0d", st0, S_IDLE); end
    areset = 1'b0; m_wvalid = '0; wready = 1'b0;
    exp_q.push_back(2'd0);
    tick();
    e = exp_q.pop_front();
    checks++; if (idx0 !== e) begin failures++; $display("FAIL mid_after_reset got=%0d exp=%0d", idx0, e); end
    checks++; if (grnt0 !== 4'b0001) begin failures++; $display("FAIL mid_after_reset_oh got=%b exp=%b", grnt0, 4'b0001); end
    awready = 1'b1; m_wvalid = 4'b0001; m_wlast = 4'b0001; wready = 1'b1;
    tick();
    m_awvalid = 4'b1000; awready = 1'b0; m_wvalid = '0; m_wlast = '0; wready = 1'b0;
    bvalid = 1'b1; m_bready = 4'b0001;
    exp_q.push_back(2'd3);
    tick();
    e = exp_q.pop_front();
    checks++; if (idx0 !== e) begin failures++; $display("FAIL mid_regrant got=%0d exp=%0d", idx0, e); end
    checks++; if (vld0 !== 1'b1) begin failures++; $display("FAIL mid_regrant_vld got=%b exp=1", vld0); end
    drive_idle();
  endtask

  task automatic test_watchdog();
    int first_to;
    int pulses;
    pulse_reset();
    first_to = -1;
    pulses   = 0;
    m_awvalid = 4'b0010;
    tick();
    checks++; if (grnt0 !== 4'b0010) begin failures++; $display("FAIL wd_grant got=%b exp=%b", grnt0, 4'b0010); end
    awready = 1'b1;
    tick();
    m_awvalid = '0; awready = 1'b0; m_wvalid = 4'b0010; m_wlast = 4'b0010; wready = 1'b1;
    tick();
    drive_idle();
    for (int k = 1; k <= 40; k++) begin
      if (k == 20) m_awvalid = 4'b0110;
      tick();
      if (to0 === 1'b1) begin
        pulses++;
        if (first_to < 0) first_to = k;
      end
`ifdef AXI_ARB_W_TIMEOUT_EN
      if (k == 33) begin
        checks++; if (vld0 !== 1'b0) begin failures++; $display("FAIL wd_drop_vld got=%b exp=0", vld0); end
        checks++; if (grnt0 !== 4'b0000) begin failures++; $display("FAIL wd_drop_grant got=%b exp=%b", grnt0, 4'b0000); end
      end
      if (k == 34) begin
        checks++; if (grnt0 !== 4'b0100) begin failures++; $display("FAIL wd_next_winner got=%b exp=%b", grnt0, 4'b0100); end
      end
`else
      if (k == 40) begin
        checks++; if (grnt0 !== 4'b0010) begin failures++; $display("FAIL wd_hold got=%b exp=%b", grnt0, 4'b0010); end
      end
`endif
    end
`ifdef AXI_ARB_W_TIMEOUT_EN
    checks++; if (first_to !== 32) begin failures++; $display("FAIL wd_latency got=%0d exp=32", first_to); end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL wd_pulse_width got=%0d exp=1", pulses); end
`else
    checks++; if (pulses !== 0) begin failures++; $display("FAIL wd_disabled got=%0d exp=0", pulses); end
`endif
    drive_idle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    areset = 1'b1;
    drive_idle();
    test_reset();
    test_single_burst();
    test_rr_order();
    test_fixed_priority();
    test_back_to_back();
    test_same_cycle();
    test_reset_mid_data();
    test_watchdog();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit reached");
  end

endmodule
